ps2_cmd_arbiter: RTL

Round-robin command scheduler that shares the single PS/2 host-to-device transmit path between several command sources, such as the init sequencer, the listen-phase resend logic and user commands like set-sample-rate. For each granted byte it launches the transmitter, waits for the device's acknowledge byte on the receive path, and retries on resend requests, transmit errors or timeouts. It then reports completion or failure to the owning requester. It sits between the command sources and the PS/2 send/read modules, at the qzt_clk level.

---
 rtl/ps2_cmd_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_cmd_arbiter.sv
// Round-robin scheduler that shares the PS/2 host-to-device path between command
// sources: launches each granted byte, waits for the device reply and retries on failure.
module ps2_cmd_arbiter #(
    parameter int N_REQ       = 3,
    parameter int ACK_TIMEOUT = 500000,
    parameter int MAX_RETRY   = 3
) (
    input  logic               qzt_clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   done,
    output logic [N_REQ-1:0]   err,
    output logic [7:0]         resp,
    output logic               busy,
    output logic [7:0]         tx_data,
    output logic               tx_start,
    input  logic               tx_done,
    input  logic               tx_err,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [PW-1:0] LAST_IDX  = PW'(N_REQ - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(ACK_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_RESEND = 8'hFE;
    localparam logic [7:0] RSP_ERROR  = 8'hFC;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_TX,
        WAIT_ACK,
        RELEASE
    } state_t;

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] v);
        return (v == LAST_IDX) ? '0 : v + 1'b1;
    endfunction

    state_t           state, state_n;
    logic [PW-1:0]    ptr, ptr_n;
    logic [PW-1:0]    owner, owner_n;
    logic [RW-1:0]    retry_cnt, retry_n;
    logic [CW-1:0]    to_cnt, to_cnt_n;
    logic [N_REQ-1:0] grant_n, done_n, err_n;
    logic             tx_start_n;
    logic [7:0]       tx_data_n, resp_n;

    logic [7:0]       req_byte [N_REQ];
    logic             sel_found;
    logic [PW-1:0]    sel_idx, cand;
    logic             do_retry, do_ok, do_fail;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req_byte
        assign req_byte[gi] = req_data[8*gi +: 8];
    end

    assign busy = (state != IDLE);

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        owner_n    = owner;
        retry_n    = retry_cnt;
        to_cnt_n   = to_cnt;
        grant_n    = grant;
        done_n     = '0;
        err_n      = '0;
        tx_start_n = 1'b0;
        tx_data_n  = tx_data;
        resp_n     = resp;
        do_retry   = 1'b0;
        do_ok      = 1'b0;
        do_fail    = 1'b0;

        // Scan requesters starting at ptr and wrapping; first set bit wins.
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = ptr;
        for (int i = 0; i < N_REQ; i++) begin
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
            cand = next_idx(cand);
        end

        case (state)
            IDLE: begin
                if (sel_found) begin
                    grant_n          = '0;
                    grant_n[sel_idx] = 1'b1;
                    owner_n          = sel_idx;
                    tx_data_n        = req_byte[sel_idx];
                    tx_start_n       = 1'b1;
                    retry_n          = '0;
                    state_n          = WAIT_TX;
                end
            end
            WAIT_TX: begin
                // Received bytes here are unsolicited traffic and are dropped.
                if (tx_done) begin
                    to_cnt_n = '0;
                    state_n  = WAIT_ACK;
                end else if (tx_err) begin
                    do_retry = 1'b1;
                end
            end
            WAIT_ACK: begin
                if (rx_valid && rx_data == RSP_ACK) begin
                    resp_n = rx_data;
                    do_ok  = 1'b1;
                end else if (rx_valid && rx_data == RSP_RESEND) begin
                    resp_n   = rx_data;
                    do_retry = 1'b1;
                end else if (rx_valid && rx_data == RSP_ERROR) begin
                    resp_n  = rx_data;
                    do_fail = 1'b1;
                end else if (to_cnt == TO_LAST) begin
                    do_retry = 1'b1;
                end else begin
                    to_cnt_n = to_cnt + 1'b1;
                end
            end
            RELEASE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (do_retry) begin
            if (retry_cnt < RETRY_MAX) begin
                retry_n    = retry_cnt + 1'b1;
                tx_start_n = 1'b1;
                state_n    = WAIT_TX;
            end else begin
                do_fail = 1'b1;
            end
        end

        if (do_ok || do_fail) begin
            done_n  = grant;
            err_n   = do_fail ? grant : '0;
            grant_n = '0;
            ptr_n   = next_idx(owner);
            state_n = RELEASE;
        end
    end

    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            retry_cnt <= '0;
            to_cnt    <= '0;
            grant     <= '0;
            done      <= '0;
            err       <= '0;
            tx_start  <= 1'b0;
            tx_data   <= 8'h00;
            resp      <= 8'h00;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            owner     <= owner_n;
            retry_cnt <= retry_n;
            to_cnt    <= to_cnt_n;
            grant     <= grant_n;
            done      <= done_n;
            err       <= err_n;
            tx_start  <= tx_start_n;
            tx_data   <= tx_data_n;
            resp      <= resp_n;
        end
    end

endmodule
